// File: rtl/hdmi_pkg.sv
// hdmi_pkg: default 1280x720 timing set, pipeline depth and helpers that
// let the clock/reset generator and the timing generator agree on the mode.
package hdmi_pkg;

  localparam int H_ACTIVE_D = 1280;
  localparam int H_FP_D     = 110;
  localparam int H_SYNC_D   = 40;
  localparam int H_BP_D     = 220;

  localparam int V_ACTIVE_D = 720;
  localparam int V_FP_D     = 5;
  localparam int V_SYNC_D   = 5;
  localparam int V_BP_D     = 20;

  localparam bit HS_POL_D   = 1'b1;
  localparam bit VS_POL_D   = 1'b1;
  localparam int PIPE_D     = 2;

  // Total clocks per line or lines per frame.
  function automatic int total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  // Counter width with a floor of one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// sig_delay: W-bit wide, D-deep shift register with per-bit reset value.
// Ports: clk, srst (sync active-high), d in, q out (d delayed D clocks).
module sig_delay #(
  parameter int           W   = 1,
  parameter int           D   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < D; i++) sr[i] <= RST;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: raster counters, pixel request stream (req/x/y) and
// hsync/vsync/de delayed PIPE clocks to align with fetched pixel data.
// Ports: clk_pix, srst in; req, x, y, frame_start, line_start,
// hsync, vsync, de out.
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit HS_POL   = HS_POL_D,
  parameter bit VS_POL   = VS_POL_D,
  parameter int PIPE     = PIPE_D
) (
  input  logic                    clk_pix,
  input  logic                    srst,
  output logic                    req,
  output logic [cw(H_ACTIVE)-1:0] x,
  output logic [cw(V_ACTIVE)-1:0] y,
  output logic                    frame_start,
  output logic                    line_start,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de
);

  localparam int HT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = cw(HT);
  localparam int VW = cw(VT);
  localparam int XW = cw(H_ACTIVE);
  localparam int YW = cw(V_ACTIVE);

  localparam int HS_B = H_ACTIVE + H_FP;
  localparam int HS_E = HS_B + H_SYNC;
  localparam int VS_B = V_ACTIVE + V_FP;
  localparam int VS_E = VS_B + V_SYNC;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_act;
  logic          v_act;
  logic          h_sy;
  logic          v_sy;
  logic          h_end;
  logic          v_end;
  logic          act;
  logic          hs0;
  logic          vs0;
  logic [2:0]    dl;

  // Compare in 32 bits so region bounds equal to the total cannot alias.
  always_comb begin
    h_act = 32'(hcnt) < H_ACTIVE;
    v_act = 32'(vcnt) < V_ACTIVE;
    h_sy  = (32'(hcnt) >= HS_B) && (32'(hcnt) < HS_E);
    v_sy  = (32'(vcnt) >= VS_B) && (32'(vcnt) < VS_E);
    h_end = 32'(hcnt) == HT - 1;
    v_end = 32'(vcnt) == VT - 1;
    act   = h_act & v_act;
  end

  always_ff @(posedge clk_pix) begin
    if (srst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      req         <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
      hs0         <= ~HS_POL;
      vs0         <= ~VS_POL;
    end else begin
      hcnt <= h_end ? '0 : hcnt + HW'(1);
      if (h_end) vcnt <= v_end ? '0 : vcnt + VW'(1);
      req         <= act;
      line_start  <= act & (hcnt == '0);
      frame_start <= act & (hcnt == '0) & (vcnt == '0);
      if (act) begin
        x <= hcnt[XW-1:0];
        y <= vcnt[YW-1:0];
      end
      // vcnt only moves at hcnt wrap, so vs0 changes at hcnt=0.
      hs0 <= h_sy ? HS_POL : ~HS_POL;
      vs0 <= v_sy ? VS_POL : ~VS_POL;
    end
  end

  sig_delay #(
    .W   (3),
    .D   (PIPE),
    .RST ({~HS_POL, ~VS_POL, 1'b0})
  ) u_dly (
    .clk  (clk_pix),
    .srst (srst),
    .d    ({hs0, vs0, req}),
    .q    (dl)
  );

  assign hsync = dl[2];
  assign vsync = dl[1];
  assign de    = dl[0];

endmodule
